// File: rtl/game_minute_clock.sv
// -----------------------------------------------------------------------------
// game_minute_clock
//
// In-game minute counter for the game state machine. Counting starts when the
// game FSM leaves INI for IDLE. It freezes on WIN/LOSE and clears on INI. The
// block also produces a one-cycle minute tick and H:MM BCD digits. The digits
// are kept up to date incrementally, so no divider is needed.
//
// Optional feature (compile-time macro PAUSE_IN_QUIZ_EN):
//   When the macro is defined, the clock pauses while quiz_active is high
//   (state HOLD). When it is undefined, quiz_active is ignored and HOLD is
//   never entered.
//
// Parameters
//   TICKS_PER_MIN  Clk cycles per in-game minute (>= 2)
//   MAX_MIN        minute count at/after which expired asserts
//
// Ports
//   Clk          in   system clock
//   Reset        in   asynchronous, active-high reset
//   q_INI        in   game FSM in INI   (clears everything)
//   q_IDLE       in   game FSM in IDLE  (starts counting)
//   q_WIN        in   game FSM in WIN   (freezes)
//   q_LOSE       in   game FSM in LOSE  (freezes)
//   quiz_active  in   any quiz state active (pause request)
//   minutes      out  [7:0] in-game minutes, saturating at 255
//   min_tick     out  one-cycle pulse in the first cycle of a new minute value
//   hr_digit     out  [3:0] BCD hours
//   min_tens     out  [3:0] BCD tens of minute-of-hour
//   min_ones     out  [3:0] BCD ones of minute-of-hour
//   running      out  clock is counting (state RUN)
//   expired      out  minutes >= MAX_MIN
// -----------------------------------------------------------------------------
module game_minute_clock #(
  parameter int TICKS_PER_MIN = 50_000_000,
  parameter int MAX_MIN       = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       q_INI,
  input  logic       q_IDLE,
  input  logic       q_WIN,
  input  logic       q_LOSE,
  input  logic       quiz_active,
  output logic [7:0] minutes,
  output logic       min_tick,
  output logic [3:0] hr_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       running,
  output logic       expired
);

  localparam int            PW      = $clog2(TICKS_PER_MIN);
  localparam logic [PW-1:0] TERM    = PW'(TICKS_PER_MIN - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);
  localparam logic [7:0]    MAX_M   = 8'(MAX_MIN);
  localparam logic [7:0]    SAT_MIN = 8'd255;

`ifdef PAUSE_IN_QUIZ_EN
  localparam logic PAUSE_EN = 1'b1;
`else
  localparam logic PAUSE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic [7:0]    minutes_next;
  logic [11:0]   bcd;            // {hours, tens, ones}
  logic [11:0]   bcd_next;
  logic          tick_next;
  logic          game_over;
  logic          pause_req;

  // Step the H:MM BCD value forward by one minute.
  function automatic logic [11:0] bcd_advance(input logic [11:0] d);
    logic [3:0] hr;
    logic [3:0] tens;
    logic [3:0] ones;
    hr   = d[11:8];
    tens = d[7:4];
    ones = d[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      if (tens == 4'd5) begin
        tens = 4'd0;
        hr   = hr + 4'd1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      ones = ones + 4'd1;
    end
    return {hr, tens, ones};
  endfunction

  assign game_over = q_WIN | q_LOSE;
  assign pause_req = PAUSE_EN & quiz_active;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= STOP;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. q_INI has top priority, then game over, then pause.
  always_comb begin
    state_next = state;
    if (q_INI) begin
      state_next = STOP;
    end else begin
      case (state)
        STOP: begin
          if (q_IDLE) begin
            state_next = RUN;
          end else begin
            state_next = STOP;
          end
        end
        RUN: begin
          if (game_over) begin
            state_next = DONE;
          end else if (pause_req) begin
            state_next = HOLD;
          end else begin
            state_next = RUN;
          end
        end
        HOLD: begin
          if (game_over) begin
            state_next = DONE;
          end else if (pause_req) begin
            state_next = HOLD;
          end else begin
            state_next = RUN;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = STOP;
      endcase
    end
  end

  // Counter next values.
  // A minute lands only in RUN, on the terminal prescaler count. The one
  // exception is a quiz resume at xF: there the minute is pushed forward
  // immediately, so the professor condition cannot re-trigger at once.
  always_comb begin
    prescaler_next = prescaler;
    minutes_next   = minutes;
    bcd_next       = bcd;
    tick_next      = 1'b0;
    if (q_INI) begin
      prescaler_next = '0;
      minutes_next   = 8'd0;
      bcd_next       = 12'd0;
    end else begin
      case (state)
        RUN: begin
          if (game_over || pause_req) begin
            prescaler_next = prescaler;
          end else if (prescaler == TERM) begin
            prescaler_next = '0;
            if (minutes != SAT_MIN) begin
              minutes_next = minutes + 8'd1;
              bcd_next     = bcd_advance(bcd);
              tick_next    = 1'b1;
            end else begin
              minutes_next = minutes;
            end
          end else begin
            prescaler_next = prescaler + PRE_ONE;
          end
        end
        HOLD: begin
          if (!game_over && !pause_req && (minutes[3:0] == 4'hF)) begin
            prescaler_next = '0;
            if (minutes != SAT_MIN) begin
              minutes_next = minutes + 8'd1;
              bcd_next     = bcd_advance(bcd);
              tick_next    = 1'b1;
            end else begin
              minutes_next = minutes;
            end
          end else begin
            prescaler_next = prescaler;
          end
        end
        default: prescaler_next = prescaler;
      endcase
    end
  end

  // Counter and tick registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescaler <= '0;
      minutes   <= 8'd0;
      bcd       <= 12'd0;
      min_tick  <= 1'b0;
    end else begin
      prescaler <= prescaler_next;
      minutes   <= minutes_next;
      bcd       <= bcd_next;
      min_tick  <= tick_next;
    end
  end

  // Output decode from registered state.
  always_comb begin
    running  = (state == RUN);
    expired  = (minutes >= MAX_M);
    hr_digit = bcd[11:8];
    min_tens = bcd[7:4];
    min_ones = bcd[3:0];
  end

endmodule

// File: tb/tb_game_minute_clock.sv
module tb_game_minute_clock;

  localparam int T = 4;

`ifdef PAUSE_IN_QUIZ_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       q_INI, q_IDLE, q_WIN, q_LOSE, quiz_active;
  logic [7:0] minutes;
  logic       min_tick;
  logic [3:0] hr_digit, min_tens, min_ones;
  logic       running, expired;

  always #5 Clk = ~Clk;

  game_minute_clock #(.TICKS_PER_MIN(T), .MAX_MIN(120)) dut (
    .Clk(Clk), .Reset(Reset),
    .q_INI(q_INI), .q_IDLE(q_IDLE), .q_WIN(q_WIN), .q_LOSE(q_LOSE),
    .quiz_active(quiz_active),
    .minutes(minutes), .min_tick(min_tick),
    .hr_digit(hr_digit), .min_tens(min_tens), .min_ones(min_ones),
    .running(running), .expired(expired)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  minutes;
    logic        tick;
    logic [11:0] bcd;
    logic        running;
    logic        expired;
  } exp_t;

  exp_t sb[$];

  // Reference model: 0 STOP, 1 RUN, 2 HOLD, 3 DONE
  int m_state = 0;
  int m_pre   = 0;
  int m_min   = 0;
  bit m_tick  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit ini, input bit idle, input bit win, input bit lose, input bit quiz);
    m_tick = 1'b0;
    if (ini) begin
      m_state = 0; m_pre = 0; m_min = 0;
    end else begin
      case (m_state)
        0: if (idle) m_state = 1;
        1: begin
          if (win || lose) m_state = 3;
          else if (PAUSE && quiz) m_state = 2;
          else if (m_pre == T - 1) begin
            m_pre = 0;
            if (m_min < 255) begin m_min++; m_tick = 1'b1; end
          end else m_pre++;
        end
        2: begin
          if (win || lose) m_state = 3;
          else if (!quiz) begin
            m_state = 1;
            if (m_min % 16 == 15) begin
              m_pre = 0;
              if (m_min < 255) begin m_min++; m_tick = 1'b1; end
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.minutes = 8'(m_min);
    e.tick    = m_tick;
    e.bcd     = {4'(m_min / 60), 4'((m_min % 60) / 10), 4'(m_min % 10)};
    e.running = (m_state == 1);
    e.expired = (m_min >= 120);
    return e;
  endfunction

  task automatic step(input bit ini, input bit idle, input bit win, input bit lose, input bit quiz);
    exp_t e;
    q_INI = ini; q_IDLE = idle; q_WIN = win; q_LOSE = lose; quiz_active = quiz;
    model_step(ini, idle, win, lose, quiz);
    sb.push_back(model_out());
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("minutes", minutes, e.minutes);
      check("min_tick", min_tick, e.tick);
      check("bcd", {hr_digit, min_tens, min_ones}, e.bcd);
      check("running", running, e.running);
      check("expired", expired, e.expired);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_min != target && guard < 4000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("reach_minutes", minutes, target);
  endtask

  initial begin
    Reset = 1'b1;
    q_INI = 1'b0; q_IDLE = 1'b0; q_WIN = 1'b0; q_LOSE = 1'b0; quiz_active = 1'b0;
    #3;
    check("rst_minutes", minutes, 0);
    check("rst_tick", min_tick, 0);
    check("rst_bcd", {hr_digit, min_tens, min_ones}, 0);
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Start: INI, then IDLE; first minute T edges after entering RUN
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("start_running", running, 1);
    idle_steps(T - 1);
    check("pre_first_min", minutes, 0);
    idle_steps(1);
    check("first_min", minutes, 1);
    check("first_tick", min_tick, 1);

    // Hour rollover, expiry, saturation
    run_to(59);
    run_to(60);
    check("h60_hr", hr_digit, 1);
    check("h60_tens", min_tens, 0);
    check("h60_ones", min_ones, 0);
    run_to(119);
    check("exp_119", expired, 0);
    run_to(120);
    check("exp_120", expired, 1);
    run_to(255);
    check("sat_hr", hr_digit, 4);
    check("sat_tens", min_tens, 1);
    check("sat_ones", min_ones, 5);
    idle_steps(20);
    check("sat_hold", minutes, 255);

    // LOSE on the terminal-count edge
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to(37);
    idle_steps(T - 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lose_min", minutes, 37);
    check("lose_tick", min_tick, 0);
    check("lose_running", running, 0);
    idle_steps(T + 1);
    check("done_frozen", minutes, 37);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ini_clear", minutes, 0);

    // Quiz pause at minute 15
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to(15);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PAUSE_IN_QUIZ_EN
    check("quiz_frozen", minutes, 15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_min", minutes, 16);
    check("resume_tick", min_tick, 1);
`else
    check("quiz_ignored", minutes, 22);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // INI beats WIN in RUN
    idle_steps(6);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("iniwin_min", minutes, 0);
    check("iniwin_running", running, 0);
    idle_steps(T + 1);
    check("stop_idle", minutes, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
